mem_resp: RTL and testbench

MEM_RESP -- requirements
Module: mem_resp

---
 rtl/mem_resp.sv | 115 +++++++++++
 tb/tb_mem_resp.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_resp.sv
// mem_resp: bus-attached memory responder serving single writes and burst reads
module mem_resp #(
    parameter int MEM_WORDS = 1024,
    parameter int RD_LAT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        selin,
    input  logic [2:0]  cmdin,
    input  logic [1:0]  lenin,
    input  logic [63:0] addrdatain,
    output logic [1:0]  reqout,
    output logic [1:0]  lenout,
    output logic [63:0] addrdataout,
    output logic [2:0]  cmdout,
    output logic [3:0]  reqtar,
    input  logic        ackin
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int LW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WDATA = 3'd1;
    localparam logic [2:0] RLAT  = 3'd2;
    localparam logic [2:0] RRESP = 3'd3;
    localparam logic [2:0] WRESP = 3'd4;
    localparam logic [2:0] C_DP   = 3'd1;
    localparam logic [2:0] C_RREQ = 3'd2;
    localparam logic [2:0] C_RRES = 3'd3;
    localparam logic [2:0] C_WREQ = 3'd4;
    localparam logic [2:0] C_WRES = 3'd5;

    logic [2:0]    state;
    logic [AW-1:0] idx;
    logic [3:0]    id;
    logic [3:0]    rem;
    logic [LW-1:0] lat;
    logic [31:0]   data_q;
    logic [31:0]   mem [MEM_WORDS];
    logic          busy;
    logic          unused_bits;

    assign unused_bits = ^{addrdatain[59:32], addrdatain[31:AW+2], addrdatain[1:0]};
    assign busy = state == RRESP || state == WRESP;

    // storage is deliberately outside the reset domain so contents survive reset
    always_ff @(posedge clk) begin
        if (state == WDATA && selin && cmdin == C_DP)
            mem[idx] <= addrdatain[31:0];
    end

    // transaction sequencing; read data is registered when each beat is launched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            id     <= '0;
            rem    <= '0;
            lat    <= '0;
            data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (selin && (cmdin == C_RREQ || cmdin == C_WREQ)) begin
                        idx   <= addrdatain[AW+1:2];
                        id    <= addrdatain[63:60];
                        rem   <= 4'd1 << lenin;
                        lat   <= '0;
                        state <= cmdin == C_RREQ ? RLAT : WDATA;
                    end
                end
                WDATA: begin
                    if (selin && cmdin == C_WREQ) begin
                        idx <= addrdatain[AW+1:2];
                        id  <= addrdatain[63:60];
                    end else if (selin && cmdin == C_DP) begin
                        state <= WRESP;
                    end
                end
                RLAT: begin
                    if (lat == LW'(RD_LAT - 1)) begin
                        state  <= RRESP;
                        data_q <= mem[idx];
                    end else begin
                        lat <= lat + 1'b1;
                    end
                end
                RRESP: begin
                    if (ackin) begin
                        if (rem == 4'd1) begin
                            state <= IDLE;
                        end else begin
                            rem    <= rem - 4'd1;
                            idx    <= idx + 1'b1;
                            data_q <= mem[idx + 1'b1];
                        end
                    end
                end
                WRESP: begin
                    if (ackin)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // response outputs are pure functions of state so reset clears them at once
    always_comb begin
        reqout      = {1'b0, busy};
        cmdout      = state == RRESP ? C_RRES : state == WRESP ? C_WRES : 3'd0;
        reqtar      = busy ? id : 4'd0;
        lenout      = state == RRESP ? 2'(rem - 4'd1) : 2'd0;
        addrdataout = {32'd0, state == RRESP ? data_q : 32'd0};
    end
endmodule

// File: tb/tb_mem_resp.sv
// tb_mem_resp: randomized self-checking bench for mem_resp against an array model
module tb_mem_resp;
    localparam int W   = 64;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        selin = 1'b0;
    logic [2:0]  cmdin = 3'd0;
    logic [1:0]  lenin = 2'd0;
    logic [63:0] addrdatain = 64'd0;
    logic        ackin = 1'b0;
    logic [1:0]  reqout;
    logic [1:0]  lenout;
    logic [63:0] addrdataout;
    logic [2:0]  cmdout;
    logic [3:0]  reqtar;

    logic [31:0] ref_mem [W];
    logic [2:0]  w_ign [6] = '{3'd0, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    logic [2:0]  i_ign [6] = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd6, 3'd7};
    int n_chk = 0;
    int n_err = 0;

    mem_resp #(.MEM_WORDS(W), .RD_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .selin(selin), .cmdin(cmdin), .lenin(lenin),
        .addrdatain(addrdatain), .reqout(reqout), .lenout(lenout),
        .addrdataout(addrdataout), .cmdout(cmdout), .reqtar(reqtar), .ackin(ackin)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_resp(input string tag, input int rq, input int cm, input int tar,
                              input int ln, input logic [63:0] dat);
        check({tag, "_req"}, 64'(reqout), 64'(rq));
        check({tag, "_cmd"}, 64'(cmdout), 64'(cm));
        check({tag, "_tar"}, 64'(reqtar), 64'(tar));
        check({tag, "_len"}, 64'(lenout), 64'(ln));
        check({tag, "_data"}, addrdataout, dat);
    endtask

    task automatic idle_bus();
        selin = 1'b0;
        cmdin = 3'd0;
        lenin = 2'd0;
        addrdatain = 64'd0;
        ackin = 1'b0;
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % W);
    endfunction

    task automatic do_write(input logic [31:0] a_first, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] id, input int gap, input int stall);
        @(negedge clk);
        if (a_first != a) begin
            selin = 1'b1;
            cmdin = 3'd4;
            addrdatain = {4'(id + 4'd1), 28'($urandom), a_first};
            @(negedge clk);
            check("wdata_req", 64'(reqout), 64'd0);
        end
        selin = 1'b1;
        cmdin = 3'd4;
        addrdatain = {id, 28'($urandom), a};
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            selin = 1'($urandom % 2);
            cmdin = w_ign[$urandom_range(0, 5)];
            addrdatain = {$urandom, $urandom};
        end
        @(negedge clk);
        selin = 1'b1;
        cmdin = 3'd1;
        addrdatain = {$urandom, d};
        @(negedge clk);
        idle_bus();
        ref_mem[widx(a)] = d;
        for (int s = 0; s <= stall; s++) begin
            check_resp("wres", 1, 5, int'(id), 0, 64'd0);
            ackin = (s == stall);
            @(negedge clk);
        end
        ackin = 1'b0;
        check("wres_done_req", 64'(reqout), 64'd0);
        check("wres_done_cmd", 64'(cmdout), 64'd0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [1:0] len, input logic [3:0] id,
                           input int smin, input int smax, input bit noise);
        int i;
        int nb;
        int st;
        @(negedge clk);
        selin = 1'b1;
        cmdin = 3'd2;
        lenin = len;
        addrdatain = {id, 28'($urandom), a};
        @(negedge clk);
        idle_bus();
        for (int k = 0; k < LAT; k++) begin
            check("rlat_req", 64'(reqout), 64'd0);
            ackin = 1'($urandom % 2);
            if (noise) begin
                selin = 1'b1;
                cmdin = 3'($urandom_range(0, 7));
                addrdatain = {$urandom, $urandom};
            end
            @(negedge clk);
        end
        ackin = 1'b0;
        i = widx(a);
        nb = 1 << len;
        for (int b = 0; b < nb; b++) begin
            st = int'($urandom_range(smin, smax));
            for (int s = 0; s <= st; s++) begin
                check_resp("rres", 1, 3, int'(id), (nb - b - 1) % 4, {32'd0, ref_mem[i]});
                if (noise) begin
                    selin = 1'b1;
                    cmdin = 3'($urandom_range(0, 7));
                    addrdatain = {$urandom, $urandom};
                end
                ackin = (s == st);
                @(negedge clk);
            end
            ackin = 1'b0;
            i = (i + 1) % W;
        end
        idle_bus();
        check_resp("rres_end", 0, 0, 0, 0, 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] a2;
        idle_bus();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        selin = 1'b1;
        cmdin = 3'd2;
        @(negedge clk);
        check_resp("reset", 0, 0, 0, 0, 64'd0);
        idle_bus();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            selin = 1'b1;
            cmdin = i_ign[$urandom_range(0, 5)];
            addrdatain = {$urandom, $urandom};
            ackin = 1'($urandom % 2);
            @(negedge clk);
            check("idle_ign_req", 64'(reqout), 64'd0);
        end
        idle_bus();
        for (int w = 0; w < W; w++)
            do_write(32'(w * 4), 32'(w * 4), $urandom, 4'($urandom), int'($urandom_range(0, 1)), 0);

        do_write(32'h40, 32'h40, 32'hDEADBEEF, 4'd2, 0, 1);
        do_read(32'h40, 2'd0, 4'd2, 0, 0, 1'b0);

        for (int w = 0; w < 4; w++)
            do_write(32'(w * 4), 32'(w * 4), 32'(w + 1), 4'd1, 0, 0);
        do_read(32'h0, 2'd2, 4'd3, 3, 3, 1'b0);

        do_read(32'((W - 2) * 4), 2'd2, 4'd5, 0, 1, 1'b0);

        do_read(32'h24, 2'd2, 4'd6, 0, 2, 1'b1);
        for (int k = 0; k < 3; k++) begin
            ackin = 1'b1;
            @(negedge clk);
            check("idle_ack_req", 64'(reqout), 64'd0);
        end
        ackin = 1'b0;

        @(negedge clk);
        selin = 1'b1;
        cmdin = 3'd2;
        lenin = 2'd2;
        addrdatain = {4'd7, 28'd0, 32'h80};
        @(negedge clk);
        idle_bus();
        repeat (LAT) @(negedge clk);
        check_resp("mid_b0", 1, 3, 7, 3, {32'd0, ref_mem[32]});
        ackin = 1'b1;
        @(negedge clk);
        ackin = 1'b0;
        check_resp("mid_b1", 1, 3, 7, 2, {32'd0, ref_mem[33]});
        reset = 1'b1;
        #1;
        check_resp("mid_rst", 0, 0, 0, 0, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < LAT + 6; k++) begin
            ackin = 1'($urandom % 2);
            @(negedge clk);
            check("post_rst_req", 64'(reqout), 64'd0);
        end
        ackin = 1'b0;
        do_read(32'h80, 2'd2, 4'd7, 0, 1, 1'b0);

        do_write(32'h10, 32'h20, 32'h55, 4'd4, 2, 0);
        do_read(32'h10, 2'd0, 4'd4, 0, 0, 1'b0);
        do_read(32'h20, 2'd0, 4'd4, 0, 0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            a = $urandom;
            if ($urandom % 2 == 0) begin
                a2 = ($urandom_range(0, 3) == 0) ? $urandom : a;
                do_write(a2, a, $urandom, 4'($urandom), int'($urandom_range(0, 2)),
                         int'($urandom_range(0, 2)));
            end else begin
                do_read(a, 2'($urandom), 4'($urandom), 0, 2, 1'($urandom % 2));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
